// File: rtl/ysyx_22040088_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time over a valid/ready
// request port, holds the returned instruction for decode and computes the next PC on commit.
module ysyx_22040088_ifu #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            imem_resp_err,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  input  logic            inst_ready,
  input  logic [2:0]      sel_nextpc,
  input  logic [XLEN-1:0] jal_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic            fetch_err,
  output logic            nextpc_err,
  output logic            misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_RST,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t          state, state_next;
  logic            resp_take;
  logic            commit;
  logic [XLEN-1:0] pc_next;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_RST;
    else        state <= state_next;
  end

  // NOTE: every output of this block is given a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    resp_take      = 1'b0;
    commit         = 1'b0;
    unique case (state)
      S_RST:  state_next = S_REQ;
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          resp_take  = 1'b1;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          commit     = 1'b1;
          state_next = S_REQ;
        end
      end
      default: state_next = S_RST;
    endcase
  end

  // Priority jalr > jal > sequential; a zero select still falls through to pc+4.
  always_comb begin
    pc_next = pc + XLEN'(4);
    if (sel_nextpc[2])      pc_next = {jalr_target[XLEN-1:1], 1'b0};
    else if (sel_nextpc[1]) pc_next = jal_target;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      inst       <= '0;
      fetch_err  <= 1'b0;
      nextpc_err <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      nextpc_err <= 1'b0;
      misalign   <= 1'b0;
      if (resp_take) begin
        inst      <= imem_resp_err ? NOP : imem_resp_data;
        fetch_err <= imem_resp_err;
      end
      if (commit) begin
        pc         <= pc_next;
        nextpc_err <= !$onehot(sel_nextpc);
        misalign   <= |pc_next[1:0];
      end
    end
  end

  assign imem_addr = pc;
  assign opcode    = inst[6:0];
  assign funct3    = inst[14:12];

endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
// Scoreboard bench for ysyx_22040088_ifu: a driver plays memory and downstream core,
// a negedge monitor compares requests, held instructions and commit pulses against queues.
module tb_ysyx_22040088_ifu;

  localparam int          XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_addr;
  logic            imem_resp_valid = 1'b0;
  logic [31:0]     imem_resp_data = '0;
  logic            imem_resp_err = 1'b0;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            inst_ready = 1'b0;
  logic [2:0]      sel_nextpc = '0;
  logic [XLEN-1:0] jal_target = '0;
  logic [XLEN-1:0] jalr_target = '0;
  logic            fetch_err;
  logic            nextpc_err;
  logic            misalign;

  ysyx_22040088_ifu #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .inst_valid(inst_valid), .inst(inst), .pc(pc), .opcode(opcode), .funct3(funct3),
    .inst_ready(inst_ready), .sel_nextpc(sel_nextpc), .jal_target(jal_target), .jalr_target(jalr_target),
    .fetch_err(fetch_err), .nextpc_err(nextpc_err), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        err;
  } inst_rec_t;

  logic [63:0] exp_addr_q[$];
  inst_rec_t   exp_inst_q[$];
  logic [1:0]  exp_pulse_q[$];   // {nextpc_err, misalign}
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] model_pc = RESET_PC;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: all output sampling happens on the falling edge.
  logic       pulse_due = 1'b0;
  logic [1:0] mon_p;
  inst_rec_t  mon_r;
  always @(negedge clk) begin
    if (rst_n) begin
      if (pulse_due) begin
        pulse_due = 1'b0;
        if (exp_pulse_q.size() == 0) check("pulse_queue_empty", 1, 0);
        else begin
          mon_p = exp_pulse_q.pop_front();
          check("nextpc_err", nextpc_err, mon_p[1]);
          check("misalign", misalign, mon_p[0]);
        end
      end
      if (imem_req_valid) begin
        if (exp_addr_q.size() == 0) check("unexpected_req", imem_addr, 0);
        else begin
          check("imem_addr", imem_addr, exp_addr_q[0]);
          if (imem_req_ready) void'(exp_addr_q.pop_front());
        end
      end
      if (inst_valid) begin
        if (exp_inst_q.size() == 0) check("unexpected_inst", inst, 0);
        else begin
          mon_r = exp_inst_q[0];
          check("inst", inst, mon_r.inst);
          check("pc", pc, mon_r.pc);
          check("opcode", opcode, mon_r.inst[6:0]);
          check("funct3", funct3, mon_r.inst[14:12]);
          check("fetch_err", fetch_err, mon_r.err);
          if (inst_ready) begin
            void'(exp_inst_q.pop_front());
            pulse_due = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    int t = 0;
    while (!imem_req_valid && t < 50) begin tick(); t++; end
    ok = imem_req_valid;
    if (!ok) check("req_timeout", 0, 1);
  endtask

  // Play one fetch: optional request backpressure, optional junk responses in REQ
  // (including the transfer cycle), then a response after resp_wait idle cycles.
  task automatic do_fetch(input logic [31:0] data, input logic err, input int req_wait,
                          input int resp_wait, input bit junk);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    imem_req_ready = 1'b0;
    for (int i = 0; i < req_wait; i++) begin
      if (junk) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = $urandom;
        imem_resp_err   = 1'($urandom);
      end
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    for (int i = 0; i < resp_wait; i++) tick();
    exp_inst_q.push_back('{model_pc, err ? 32'h0000_0013 : data, err});
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    imem_resp_err   = err;
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    imem_resp_err   = 1'b0;
    check("inst_valid_latency", inst_valid, 1);
  endtask

  // Commit after 'hold' stalled cycles, with random junk on the select inputs while stalled.
  task automatic do_commit(input logic [2:0] sel, input logic [63:0] jal,
                           input logic [63:0] jalr, input int hold);
    logic [63:0] nxt;
    int t = 0;
    while (!inst_valid && t < 50) begin tick(); t++; end
    if (!inst_valid) begin check("inst_timeout", 0, 1); return; end
    inst_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      sel_nextpc  = 3'($urandom);
      jal_target  = {$urandom, $urandom};
      jalr_target = {$urandom, $urandom};
      tick();
    end
    if (sel[2])      nxt = jalr & ~64'h1;
    else if (sel[1]) nxt = jal;
    else             nxt = model_pc + 64'd4;
    exp_pulse_q.push_back({($countones(sel) != 1), (nxt[1:0] != 2'b00)});
    exp_addr_q.push_back(nxt);
    model_pc    = nxt;
    inst_ready  = 1'b1;
    sel_nextpc  = sel;
    jal_target  = jal;
    jalr_target = jalr;
    tick();
    inst_ready  = 1'b0;
    sel_nextpc  = 3'($urandom);
    jal_target  = {$urandom, $urandom};
    jalr_target = {$urandom, $urandom};
    check("req_after_commit", imem_req_valid, 1);
    check("inst_valid_cleared", inst_valid, 0);
  endtask

  task automatic apply_reset(input int cycles, input bit stale);
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_pc", pc, RESET_PC);
    check("rst_opcode", opcode, 0);
    check("rst_funct3", funct3, 0);
    check("rst_fetch_err", fetch_err, 0);
    check("rst_nextpc_err", nextpc_err, 0);
    check("rst_misalign", misalign, 0);
    model_pc = RESET_PC;
    exp_addr_q.push_back(RESET_PC);
    if (stale) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hdead_beef;
      imem_resp_err   = 1'b1;
    end
    rst_n = 1'b1;
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
  endtask

  function automatic logic [63:0] rand_target();
    logic [63:0] v = {$urandom, $urandom};
    if ($urandom_range(0, 7) != 0) v[1:0] = 2'b00;
    return v;
  endfunction

  initial begin
    bit          ok;
    logic [2:0]  sel;
    logic [63:0] one = 64'd1;

    apply_reset(2, 1'b0);

    // Sequential fetch, then jal and jalr selection
    do_fetch(32'h0010_0093, 1'b0, 0, 0, 1'b0);
    do_commit(3'b001, '0, '0, 0);
    do_fetch($urandom, 1'b0, 0, 0, 1'b0);
    do_commit(3'b010, 64'h8000_0100, 64'h1234, 0);
    do_fetch($urandom, 1'b0, 0, 1, 1'b0);
    do_commit(3'b100, 64'h5678, 64'h8000_0205, 0);

    // Backpressure on both sides, junk responses while in REQ
    do_fetch($urandom, 1'b0, 5, 2, 1'b1);
    do_commit(3'b001, '0, '0, 10);

    // Error response, zero and multi-hot selects, misaligned target
    do_fetch($urandom, 1'b1, 0, 0, 1'b0);
    do_commit(3'b000, 64'h9999_0000, 64'h7777_0000, 1);
    do_fetch($urandom, 1'b0, 0, 0, 1'b0);
    do_commit(3'b110, 64'h8000_0400, 64'h8000_0300, 0);
    do_fetch($urandom, 1'b0, 0, 0, 1'b0);
    do_commit(3'b010, 64'h8000_0102, 64'h0, 0);

    // Wrap-around of pc+4
    do_fetch($urandom, 1'b0, 0, 0, 1'b0);
    do_commit(3'b010, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0);
    do_fetch($urandom, 1'b0, 0, 0, 1'b0);
    do_commit(3'b001, '0, '0, 0);

    // Reset while WAITing, with a stale response landing in RST
    do_fetch($urandom, 1'b1, 0, 0, 1'b0);
    do_commit(3'b001, '0, '0, 0);
    wait_req(ok);
    if (ok) begin
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      check("fetch_err_kept_in_wait", fetch_err, 1);
    end
    void'(exp_pulse_q.size());
    apply_reset(1, 1'b1);
    do_fetch(32'h0000_6033, 1'b0, 0, 0, 1'b0);
    do_commit(3'b001, '0, '0, 0);

    // Randomised traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 6) sel = 3'(one << $urandom_range(0, 2));
      else                          sel = 3'($urandom_range(0, 7));
      do_fetch($urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
               $urandom_range(0, 3), 1'($urandom));
      do_commit(sel, rand_target(), rand_target(), $urandom_range(0, 3));
    end

    tick();
    tick();
    check("inst_queue_drained", exp_inst_q.size(), 0);
    check("pulse_queue_drained", exp_pulse_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
